serial_frame_demux: RTL and testbench
=====================================

Name: serial_frame_demux

Overview:
Parametrised successor to the lab-2 serial port demultiplexer. It receives framed serial data bit-by-bit, qualified by a one-cycle bit strobe from the one-pulser. Each frame is: start bit, PORT_W-bit port number, LEN_W-bit length, then `length` payload bits. Payload bits are steered to one of 2**PORT_W output ports, with a live remaining-count output for the SSD. Port width, length width and zero-length frames are generalised; the fixed 2-port/4-bit-length design handled none of these.

Parameters:
PORT_W, 2, port-number field width; NUM_PORTS = 2**PORT_W (localparam); PORT_W >= 1
LEN_W, 4, length field width; payload is 0 .. 2**LEN_W-1 bits; LEN_W >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
clk_en  input  1  bit strobe; one bit of ser_in is consumed on each clk edge where clk_en=1
ser_in  input  1  serial line; idles high
p  output  NUM_PORTS  port outputs; p[k] carries payload for port k
port_num  output  PORT_W  captured port number of the current or last frame
d_cnt  output  LEN_W  payload bits still to be delivered
ser_out_valid  output  1  high throughout the DATA state
busy  output  1  high in every state except IDLE
done  output  1  one clk-cycle pulse at end of frame

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. port_num, d_cnt, the internal shift registers and the bit counter all clear to 0. p=0, ser_out_valid=0, busy=0, done=0. Reset asserted mid-frame aborts the frame immediately; no done pulse is produced.
- Strobe gating: all state, counter and shift updates happen only on edges where clk_en=1. The single exception is the DONE->IDLE transition, which is unconditional. If clk_en=0, everything holds.
- IDLE: on a strobe with ser_in=0, load the bit counter with 0 and go to PORT. On a strobe with ser_in=1, stay in IDLE.
- PORT: each strobe shifts ser_in into port_num, MSB first: port_num <= {port_num[PORT_W-2:0], ser_in}. For PORT_W=1, port_num <= ser_in. On the strobe that delivers the PORT_W-th bit, clear the bit counter and go to LEN.
- LEN: each strobe shifts ser_in into an internal length register, MSB first. On the strobe that delivers the LEN_W-th bit, d_cnt loads the full assembled length, including that final bit.
  - Assembled length == 0: go directly to DONE.
  - Otherwise: go to DATA.
- DATA: ser_out_valid=1. Routing is combinational: p[k] = ser_in when ser_out_valid=1 and k==port_num, else 0. Each strobe decrements d_cnt. A strobe with d_cnt==1 sets d_cnt to 0 and goes to DONE. d_cnt never wraps below 0.
- DONE: done=1 and busy=1 for exactly one clk cycle, then IDLE. port_num holds its value until the next frame's PORT bits arrive.
- Back-to-back frames: a new start bit is accepted only on a strobe in IDLE, so at least one strobe follows DONE before the next frame.
- Bit counter width: $clog2(max(PORT_W,LEN_W))+1.
- Outputs: all outputs are registered or decoded from state, except p, which is the combinational routing above.

Decomposition:
- Shared header/package serial_frame_pkg holds:
  - state encodings: IDLE, PORT, LEN, DATA, DONE (3-bit);
  - the NUM_PORTS derivation;
  - the counter-width function.
- One sub-module, sfd_controller, contains the FSM and the bit counter. It drives these control strobes to the datapath: sh_port, sh_len, ld_cnt, dec_cnt, ser_out_valid, done.
- The shift registers, down-counter and demux stay inline in serial_frame_demux.

Test Plan:
- PORT_W=2, LEN_W=4, one strobe per 2 clocks, bits 0,1,0,0,0,1,1,1,0,1:
  - port_num=2 after the PORT bits; d_cnt=3 after the LEN bits;
  - p[2] shows 1,0,1 while ser_out_valid=1; p[0], p[1] and p[3] stay 0;
  - d_cnt steps 3,2,1,0; done pulses exactly 1 clk after the third payload strobe.
- Zero length, bits 0,1,1,0,0,0,0: port_num=3, ser_out_valid never rises, done pulses 1 clk after the last length strobe.
- ser_in=1 held for 20 strobes: stays IDLE, busy=0, p=0. Then ser_in=0 with clk_en=0 for 5 clks: still IDLE (no strobe).
- Reset during DATA with d_cnt=5 (length 9 sent to port 1): all outputs 0 asynchronously, no done pulse. After rst deasserts, a full frame completes normally.
- PORT_W=3, LEN_W=5, length 31 to port 6, with irregular strobe gaps: p[6] mirrors all 31 payload bits, d_cnt reaches 0, done pulses once.
- Two frames back-to-back (port 1 len 2, then port 0 len 1, one idle strobe between them): done pulses twice; each payload appears only on its own port.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared state encoding and width helpers for the serial frame demultiplexer.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PORT = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic int unsigned num_ports(input int unsigned port_w);
    return 32'(1) << port_w;
  endfunction

  // Bit counter must index the wider of the two header fields.
  function automatic int unsigned cnt_width(input int unsigned port_w, input int unsigned len_w);
    int unsigned m;
    m = (port_w > len_w) ? port_w : len_w;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sfd_controller.sv
// Frame sequencing FSM and header bit counter; emits datapath control strobes.
module sfd_controller
  import serial_frame_pkg::*;
#(
  parameter int unsigned PORT_W = 2,
  parameter int unsigned LEN_W  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic ser_in,
  input  logic len_zero,
  input  logic cnt_one,
  output logic sh_port,
  output logic sh_len,
  output logic ld_cnt,
  output logic dec_cnt,
  output logic ser_out_valid,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = cnt_width(PORT_W, LEN_W);
  localparam logic [CNT_W-1:0] PORT_LAST = CNT_W'(PORT_W - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             valid_q, busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_port   = 1'b0;
    sh_len    = 1'b0;
    ld_cnt    = 1'b0;
    dec_cnt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clk_en && !ser_in) begin
          state_d   = PORT;
          bit_cnt_d = '0;
        end
      end
      PORT: begin
        if (clk_en) begin
          sh_port = 1'b1;
          if (bit_cnt_q == PORT_LAST) begin
            bit_cnt_d = '0;
            state_d   = LEN;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      LEN: begin
        if (clk_en) begin
          sh_len = 1'b1;
          if (bit_cnt_q == LEN_LAST) begin
            ld_cnt    = 1'b1;
            bit_cnt_d = '0;
            state_d   = len_zero ? DONE : DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (clk_en) begin
          dec_cnt = 1'b1;
          if (cnt_one) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= (state_d == DATA);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign ser_out_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: rtl/serial_frame_demux.sv
// Framed serial receiver: captures port/length header and steers payload bits to one port.
module serial_frame_demux
  import serial_frame_pkg::*;
#(
  parameter int unsigned PORT_W = 2,
  parameter int unsigned LEN_W  = 4,
  localparam int unsigned NUM_PORTS = num_ports(PORT_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 ser_in,
  output logic [NUM_PORTS-1:0] p,
  output logic [PORT_W-1:0]    port_num,
  output logic [LEN_W-1:0]     d_cnt,
  output logic                 ser_out_valid,
  output logic                 busy,
  output logic                 done
);

  logic              sh_port, sh_len, ld_cnt, dec_cnt;
  logic              len_zero_c, cnt_one_c;
  logic [PORT_W-1:0] port_q, port_d;
  logic [LEN_W-1:0]  len_q, len_d, len_next_c;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  sfd_controller #(
    .PORT_W (PORT_W),
    .LEN_W  (LEN_W)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .ser_in        (ser_in),
    .len_zero      (len_zero_c),
    .cnt_one       (cnt_one_c),
    .sh_port       (sh_port),
    .sh_len        (sh_len),
    .ld_cnt        (ld_cnt),
    .dec_cnt       (dec_cnt),
    .ser_out_valid (ser_out_valid),
    .busy          (busy),
    .done          (done)
  );

  // Truncating the concatenation drops the MSB, which also covers 1-bit fields.
  assign len_next_c = LEN_W'({len_q, ser_in});
  assign len_zero_c = (len_next_c == '0);
  assign cnt_one_c  = (cnt_q == LEN_W'(1));

  always_comb begin
    port_d = port_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if (sh_port) port_d = PORT_W'({port_q, ser_in});
    if (sh_len)  len_d  = len_next_c;
    if (ld_cnt) begin
      cnt_d = len_next_c;
    end else if (dec_cnt && cnt_q != '0) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      port_q <= port_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    p = '0;
    if (ser_out_valid) p[port_q] = ser_in;
  end

  assign port_num = port_q;
  assign d_cnt    = cnt_q;

endmodule

// File: tb/tb_serial_frame_demux.sv
// Directed bench: instance a uses the default 2/4 geometry, instance b a 3/5 geometry.
module tb_serial_frame_demux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_a = 1'b0, ser_a = 1'b1;
  logic en_b = 1'b0, ser_b = 1'b1;

  logic [3:0] p_a;
  logic [1:0] port_a;
  logic [3:0] dcnt_a;
  logic       vld_a, busy_a, done_a;

  logic [7:0] p_b;
  logic [2:0] port_b;
  logic [4:0] dcnt_b;
  logic       vld_b, busy_b, done_b;

  int n_pass = 0;
  int n_tot  = 0;
  int dones_a = 0, dones_b = 0, vlds_a = 0;
  int snap, snap_v;
  logic [30:0] pat;
  logic        bit_v;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done_a) dones_a++;
    if (done_b) dones_b++;
    if (vld_a)  vlds_a++;
  end

  serial_frame_demux #(.PORT_W(2), .LEN_W(4)) dut_a (
    .clk(clk), .rst(rst), .clk_en(en_a), .ser_in(ser_a), .p(p_a), .port_num(port_a),
    .d_cnt(dcnt_a), .ser_out_valid(vld_a), .busy(busy_a), .done(done_a)
  );

  serial_frame_demux #(.PORT_W(3), .LEN_W(5)) dut_b (
    .clk(clk), .rst(rst), .clk_en(en_b), .ser_in(ser_b), .p(p_b), .port_num(port_b),
    .d_cnt(dcnt_b), .ser_out_valid(vld_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One strobe on instance a; returns at the following negedge with the result visible.
  task automatic sa(input logic b);
    @(negedge clk);
    ser_a = b;
    en_a  = 1'b1;
    @(negedge clk);
    en_a  = 1'b0;
  endtask

  task automatic sb(input logic b, input int gap);
    @(negedge clk);
    ser_b = b;
    en_b  = 1'b1;
    @(negedge clk);
    en_b  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_p", 32'(p_a), 0);
    check("rst_port", 32'(port_a), 0);
    check("rst_dcnt", 32'(dcnt_a), 0);
    check("rst_flags", 32'({vld_a, busy_a, done_a}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Frame to port 2, length 3, payload 1,0,1
    sa(1'b0); sa(1'b1); sa(1'b0);
    check("a_port2", 32'(port_a), 2);
    check("a_busy_hdr", 32'(busy_a), 1);
    sa(1'b0); sa(1'b0); sa(1'b1); sa(1'b1);
    check("a_dcnt3", 32'(dcnt_a), 3);
    check("a_vld", 32'(vld_a), 1);
    snap = dones_a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_v = (i != 1);
      ser_a = bit_v;
      en_a  = 1'b1;
      #1;
      check("a_p_route", 32'(p_a), bit_v ? 32'h4 : 32'h0);
      check("a_done_early", 32'(done_a), 0);
      @(negedge clk);
      en_a = 1'b0;
      check("a_dcnt_step", 32'(dcnt_a), 32'(2 - i));
    end
    check("a_done_pulse", 32'(done_a), 1);
    check("a_vld_off", 32'(vld_a), 0);
    @(negedge clk);
    check("a_done_end", 32'(done_a), 0);
    check("a_idle", 32'(busy_a), 0);
    check("a_done_cnt", 32'(dones_a - snap), 1);

    // Zero-length frame to port 3
    ser_a = 1'b1;
    snap = dones_a;
    snap_v = vlds_a;
    sa(1'b0); sa(1'b1); sa(1'b1);
    check("z_port3", 32'(port_a), 3);
    sa(1'b0); sa(1'b0); sa(1'b0); sa(1'b0);
    check("z_done", 32'(done_a), 1);
    check("z_dcnt", 32'(dcnt_a), 0);
    @(negedge clk);
    check("z_done_end", 32'(done_a), 0);
    check("z_no_vld", 32'(vlds_a - snap_v), 0);
    check("z_done_cnt", 32'(dones_a - snap), 1);

    // Idle line: no frame starts
    for (int i = 0; i < 20; i++) sa(1'b1);
    check("i_busy", 32'(busy_a), 0);
    check("i_p", 32'(p_a), 0);
    @(negedge clk);
    ser_a = 1'b0;
    repeat (5) @(negedge clk);
    check("i_noen_busy", 32'(busy_a), 0);
    ser_a = 1'b1;

    // Reset during DATA: port 1, length 9, four payload bits sent
    sa(1'b0); sa(1'b0); sa(1'b1);
    sa(1'b1); sa(1'b0); sa(1'b0); sa(1'b1);
    sa(1'b1); sa(1'b0); sa(1'b1); sa(1'b1);
    check("r_dcnt5", 32'(dcnt_a), 5);
    check("r_port1", 32'(port_a), 1);
    snap = dones_a;
    @(negedge clk);
    ser_a = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("r_async_p", 32'(p_a), 0);
    check("r_async_dcnt", 32'(dcnt_a), 0);
    check("r_async_port", 32'(port_a), 0);
    check("r_async_flags", 32'({vld_a, busy_a, done_a}), 0);
    repeat (3) @(negedge clk);
    check("r_no_done", 32'(dones_a - snap), 0);
    rst = 1'b1;
    // Recovery frame: port 3, length 2, payload 1,1
    sa(1'b0); sa(1'b1); sa(1'b1);
    sa(1'b0); sa(1'b0); sa(1'b1); sa(1'b0);
    check("r2_dcnt", 32'(dcnt_a), 2);
    @(negedge clk);
    ser_a = 1'b1;
    en_a  = 1'b1;
    #1;
    check("r2_p", 32'(p_a), 32'h8);
    @(negedge clk);
    en_a = 1'b0;
    sa(1'b1);
    check("r2_done", 32'(done_a), 1);
    check("r2_port", 32'(port_a), 3);

    // Back-to-back frames: port 1 len 2, idle strobe, port 0 len 1
    @(negedge clk);
    snap = dones_a;
    sa(1'b0); sa(1'b0); sa(1'b1);
    sa(1'b0); sa(1'b0); sa(1'b1); sa(1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ser_a = 1'b1;
      en_a  = 1'b1;
      #1;
      check("bb1_p", 32'(p_a), 32'h2);
      @(negedge clk);
      en_a = 1'b0;
    end
    sa(1'b1);
    sa(1'b0); sa(1'b0); sa(1'b0);
    sa(1'b0); sa(1'b0); sa(1'b0); sa(1'b1);
    check("bb2_port", 32'(port_a), 0);
    @(negedge clk);
    ser_a = 1'b1;
    en_a  = 1'b1;
    #1;
    check("bb2_p", 32'(p_a), 32'h1);
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    check("bb_done_cnt", 32'(dones_a - snap), 2);

    // Instance b: length 31 to port 6 with irregular strobe gaps
    pat = 31'h2D1E_4B97;
    snap = dones_b;
    sb(1'b0, 1); sb(1'b1, 0); sb(1'b1, 2); sb(1'b0, 0);
    check("b_port6", 32'(port_b), 6);
    for (int i = 0; i < 5; i++) sb(1'b1, i % 2);
    check("b_dcnt31", 32'(dcnt_b), 31);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      bit_v = pat[i];
      ser_b = bit_v;
      en_b  = 1'b1;
      #1;
      check("b_p_mirror", 32'(p_b), bit_v ? 32'h40 : 32'h0);
      @(negedge clk);
      en_b = 1'b0;
      if (i != 30) repeat (i % 3) @(negedge clk);
    end
    check("b_done", 32'(done_b), 1);
    check("b_dcnt0", 32'(dcnt_b), 0);
    @(negedge clk);
    check("b_idle", 32'(busy_b), 0);
    check("b_done_cnt", 32'(dones_b - snap), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
